// File: rtl/fpmu_pkg.sv
// Shared definitions for the FP16 multiplier result path: field widths,
// exponent constants, special encodings and the transmit FSM state type.
package fpmu_pkg;

  localparam int EXP_W    = 5;
  localparam int MANT_W   = 11;
  localparam int PROD_W   = 22;
  localparam int EXP_BIAS = 15;
  localparam int EXP_MAX  = 31;

  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_SEND0 = 2'd2,
    ST_SEND1 = 2'd3
  } state_t;

endpackage

// File: rtl/fp16_norm_round.sv
// Combinational normalise / round-to-nearest-even / re-bias / pack of a raw
// 11x11 mantissa product into an IEEE 754 half-precision word. Subnormal
// results are never produced: they flush to signed zero with the unf flag.
module fp16_norm_round #(
  parameter int EXP_BIAS = fpmu_pkg::EXP_BIAS
) (
  input  logic                        sign_i,
  input  logic [fpmu_pkg::PROD_W-1:0] mant_i,
  input  logic [5:0]                  exp_i,
  output logic [15:0]                 word_o,
  output logic                        ovf_o,
  output logic                        unf_o
);

  logic [fpmu_pkg::MANT_W-2:0] field;
  logic [fpmu_pkg::MANT_W-2:0] field_r;
  logic                        guard_bit;
  logic                        sticky_bit;
  logic                        adj;
  logic                        round_up;
  logic                        carry;
  logic [1:0]                  adj_tot;
  logic signed [7:0]           exp_s;

  // Normalise, round, re-bias, then choose zero / underflow / overflow / normal.
  always_comb begin
    field      = '0;
    guard_bit  = 1'b0;
    sticky_bit = 1'b0;
    adj        = 1'b0;
    round_up   = 1'b0;
    carry      = 1'b0;
    field_r    = '0;
    adj_tot    = '0;
    exp_s      = '0;
    word_o     = '0;
    ovf_o      = 1'b0;
    unf_o      = 1'b0;

    // Product of two 1.x mantissas lies in [1,4): bit 21 set means [2,4).
    if (mant_i[21]) begin
      field      = mant_i[20:11];
      guard_bit  = mant_i[10];
      sticky_bit = |mant_i[9:0];
      adj        = 1'b1;
    end else begin
      field      = mant_i[19:10];
      guard_bit  = mant_i[9];
      sticky_bit = |mant_i[8:0];
      adj        = 1'b0;
    end

    round_up         = guard_bit & (sticky_bit | field[0]);
    {carry, field_r} = {1'b0, field} + {10'b0, round_up};
    adj_tot          = {1'b0, adj} + {1'b0, carry};

    exp_s = $signed({2'b00, exp_i}) - $signed(8'(EXP_BIAS)) + $signed({6'b0, adj_tot});

    // A product without a hidden bit in 21:20 came from a zero/subnormal operand.
    if (mant_i[21:20] == 2'b00) begin
      word_o = {sign_i, 15'h0};
    end else if (exp_s <= 8'sd0) begin
      word_o = {sign_i, 15'h0};
      unf_o  = 1'b1;
    end else if (exp_s >= $signed(8'(fpmu_pkg::EXP_MAX))) begin
      word_o = sign_i ? fpmu_pkg::NEG_INF : fpmu_pkg::POS_INF;
      ovf_o  = 1'b1;
    end else begin
      word_o = {sign_i, exp_s[4:0], field_r};
    end
  end

endmodule

// File: rtl/fpmu_result_tx.sv
// Transmit end of the FP16 multiplier: captures one raw product, converts it
// to a half-precision word and streams it out as two bytes.
//
// Handshake semantics (both interfaces): a transfer happens on a rising clock
// edge where valid and ready are both high. in_ready is high only in IDLE;
// the producer holds in_* until it sees in_ready. Once tx_valid is raised,
// tx_data/tx_last/ovf/unf stay unchanged until the byte is accepted.
module fpmu_result_tx
  import fpmu_pkg::*;
#(
  parameter int EXP_BIAS  = fpmu_pkg::EXP_BIAS,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [PROD_W-1:0]     in_mant,
  input  logic [5:0]            in_exp,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  ovf,
  output logic                  unf,
  output logic [1:0]            dbg_state
);

  state_t              state_q;
  logic                in_ready_q;
  logic                sign_q;
  logic [PROD_W-1:0]   mant_q;
  logic [5:0]          cap_exp_q;
  logic [15:0]         word_q;
  logic                ovf_q;
  logic                unf_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                tx_last_q;

  logic [15:0]         nr_word;
  logic                nr_ovf;
  logic                nr_unf;
  logic [7:0]          first_byte;
  logic [7:0]          second_byte;

  fp16_norm_round #(
    .EXP_BIAS(EXP_BIAS)
  ) u_norm_round (
    .sign_i (sign_q),
    .mant_i (mant_q),
    .exp_i  (cap_exp_q),
    .word_o (nr_word),
    .ovf_o  (nr_ovf),
    .unf_o  (nr_unf)
  );

  // Byte order selection for the serialiser.
  assign first_byte  = (MSB_FIRST != 0) ? word_q[15:8] : word_q[7:0];
  assign second_byte = (MSB_FIRST != 0) ? word_q[7:0]  : word_q[15:8];

  // Control FSM with registered handshake and byte outputs. The first SEND0
  // cycle loads the output register, so the first byte is valid two edges
  // after capture; the second byte follows directly on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      in_ready_q <= 1'b1;
      sign_q     <= 1'b0;
      mant_q     <= '0;
      cap_exp_q  <= '0;
      word_q     <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            sign_q     <= in_sign;
            mant_q     <= in_mant;
            cap_exp_q  <= in_exp;
            in_ready_q <= 1'b0;
            state_q    <= ST_NORM;
          end
        end
        ST_NORM: begin
          word_q  <= nr_word;
          ovf_q   <= nr_ovf;
          unf_q   <= nr_unf;
          state_q <= ST_SEND0;
        end
        ST_SEND0: begin
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= first_byte;
            tx_last_q  <= 1'b0;
          end else if (tx_ready) begin
            tx_data_q <= second_byte;
            tx_last_q <= 1'b1;
            state_q   <= ST_SEND1;
          end
        end
        ST_SEND1: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            tx_data_q  <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_last   = tx_last_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign dbg_state = state_q;

endmodule
